m2_wr_capture: RTL and testbench



---
 rtl/m2_wr_capture_pkg.sv | 31 +++
 rtl/m2_wr_capture_if.sv | 16 +
 rtl/m2_wr_capture_wr_fifo2.sv | 73 +++++++
 rtl/m2_wr_capture.sv | 160 ++++++++++++++++
 tb/tb_m2_wr_capture.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/m2_wr_capture_pkg.sv
// m2_wr_capture_pkg: definitions shared by the M2 write-capture front end.
//   - m2_state_e : capture FSM encoding (idle / M2-high phase)
//   - wr_entry_t : one buffered write, {addr, dat}
//   - SEL_*_DEF  : default decode for the $8000-$FFFF register window
//   - sel_hit()  : masked address compare used for write selection
package m2_wr_capture_pkg;

  localparam int ADDR_W  = 16;
  localparam int DAT_W   = 8;
  localparam int ENTRY_W = ADDR_W + DAT_W;  // 24-bit write record

  localparam logic [ADDR_W-1:0] SEL_MASK_DEF  = 16'h8000;
  localparam logic [ADDR_W-1:0] SEL_MATCH_DEF = 16'h8000;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HIGH = 1'b1
  } m2_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DAT_W-1:0]  dat;
  } wr_entry_t;

  function automatic logic sel_hit(input logic [ADDR_W-1:0] addr,
                                   input logic [ADDR_W-1:0] mask,
                                   input logic [ADDR_W-1:0] match);
    return (addr & mask) == match;
  endfunction

endpackage

// File: rtl/m2_wr_capture_if.sv
// m2_wr_capture_if: valid/ready write stream leaving the capture stage.
//   wr_valid : head entry present            (master -> slave)
//   wr_ready : consumer takes head this cycle (slave -> master)
//   wr_addr  : head address                  (master -> slave)
//   wr_dat   : head data                     (master -> slave)
interface m2_wr_capture_if;
  import m2_wr_capture_pkg::*;

  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DAT_W-1:0]  wr_dat;

  modport master (output wr_valid, output wr_addr, output wr_dat, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_dat, output wr_ready);
endinterface

// File: rtl/m2_wr_capture_wr_fifo2.sv
// wr_fifo2: 2-entry valid/ready buffer for captured CPU writes.
//   clk, rst   : clock, asynchronous active-high reset
//   push       : one-cycle request to store push_data
//   push_data  : entry to store
//   wr         : head of buffer as a valid/ready stream (master side)
//   ovf        : sticky, a push was dropped because the buffer was full
// No bypass: an entry pushed into an empty buffer appears the next cycle.
module wr_fifo2
  import m2_wr_capture_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  wr_entry_t               push_data,
  m2_wr_capture_if.master         wr,
  output logic                    ovf
);

  wr_entry_t  mem_q [2];
  wr_entry_t  mem_d [2];
  logic       rd_ptr_q, rd_ptr_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic [1:0] count_q, count_d;
  logic       ovf_q, ovf_d;
  logic       pop;
  logic       push_ok;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    ovf_d    = ovf_q;
    pop      = (count_q != 2'd0) && wr.wr_ready;
    // When full, a simultaneous pop frees the slot the push lands in.
    push_ok  = push && ((count_q != 2'd2) || pop);

    if (pop) rd_ptr_d = ~rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (push && !push_ok) ovf_d = 1'b1;

    count_d = count_q + {1'b0, push_ok} - {1'b0, pop};
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_mem
    always_ff @(posedge clk or posedge rst) begin
      if (rst) mem_q[gi] <= '0;
      else     mem_q[gi] <= mem_d[gi];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      ovf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  assign wr.wr_valid = (count_q != 2'd0);
  assign wr.wr_addr  = mem_q[rd_ptr_q].addr;
  assign wr.wr_dat   = mem_q[rd_ptr_q].dat;
  assign ovf         = ovf_q;

endmodule

// File: rtl/m2_wr_capture.sv
// m2_wr_capture: brings the asynchronous NES CPU bus into the clk domain and
// turns each qualified M2 low-going edge into one buffered write.
//   clk, map_rst          : system clock, asynchronous active-high reset
//   m2, cpu_rw, cpu_addr,
//   cpu_dat               : raw CPU pins (synchronised here, equal delay)
//   wr                    : captured-write stream (master side)
//   m2_fall               : pulse on every synchronised M2 fall
//   glitch                : pulse when a too-short M2 high pulse is discarded
//   ovf                   : sticky, a qualified write was dropped (buffer full)
module m2_wr_capture
  import m2_wr_capture_pkg::*;
#(
  parameter int                SYNC_STAGES = 2,
  parameter int                MIN_HIGH    = 3,
  parameter logic [ADDR_W-1:0] SEL_MASK    = SEL_MASK_DEF,
  parameter logic [ADDR_W-1:0] SEL_MATCH   = SEL_MATCH_DEF
) (
  input  logic              clk,
  input  logic              map_rst,
  input  logic              m2,
  input  logic              cpu_rw,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DAT_W-1:0]  cpu_dat,
  m2_wr_capture_if.master   wr,
  output logic              m2_fall,
  output logic              glitch,
  output logic              ovf
);

  localparam int SYNC_W = 2 + ADDR_W + DAT_W;  // {m2, rw, addr, dat}

  // Synchroniser: the whole bundle shifts together so m2 and the bus keep
  // their original relative timing.
  for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
    logic [SYNC_W-1:0] stage_q;
    logic [SYNC_W-1:0] stage_d;
    if (gi == 0) begin : g_first
      assign stage_d = {m2, cpu_rw, cpu_addr, cpu_dat};
    end else begin : g_next
      assign stage_d = g_sync[gi-1].stage_q;
    end
    always_ff @(posedge clk or posedge map_rst) begin
      if (map_rst) stage_q <= '0;
      else         stage_q <= stage_d;
    end
  end

  logic [SYNC_W-1:0] sync_s;
  logic              m2_s, rw_s;
  logic [ADDR_W-1:0] addr_s;
  logic [DAT_W-1:0]  dat_s;

  assign sync_s = g_sync[SYNC_STAGES-1].stage_q;
  assign {m2_s, rw_s, addr_s, dat_s} = sync_s;

  m2_state_e         state_q, state_d;
  logic              m2_d_q, m2_d_d;
  logic [3:0]        hcnt_q, hcnt_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DAT_W-1:0]  dat_q, dat_d;
  logic              push_q, push_d;
  logic              m2_fall_q, m2_fall_d;
  logic              glitch_q, glitch_d;
  // The chain is zero right after reset, so a pulse already in progress
  // would look like a fresh rise. fill_q counts until the last stage holds a
  // real sample; armed_q then waits for a genuine low before accepting rises.
  logic [2:0]        fill_q, fill_d;
  logic              armed_q, armed_d;
  logic              fill_done;

  assign fill_done = (fill_q == 3'(SYNC_STAGES));

  always_comb begin
    state_d   = state_q;
    m2_d_d    = m2_s;
    hcnt_d    = hcnt_q;
    rw_d      = rw_q;
    addr_d    = addr_q;
    dat_d     = dat_q;
    push_d    = 1'b0;
    m2_fall_d = 1'b0;
    glitch_d  = 1'b0;
    fill_d    = fill_done ? fill_q : fill_q + 3'd1;
    armed_d   = armed_q || (fill_done && !m2_s);

    case (state_q)
      ST_IDLE: begin
        if (armed_q && m2_s && !m2_d_q) begin
          state_d = ST_HIGH;
          hcnt_d  = 4'd1;
          rw_d    = rw_s;
          addr_d  = addr_s;
          dat_d   = dat_s;
        end
      end
      ST_HIGH: begin
        if (m2_s) begin
          // Keep relatching: CPU write data settles late in the cycle.
          rw_d   = rw_s;
          addr_d = addr_s;
          dat_d  = dat_s;
          if (hcnt_q != 4'd15) hcnt_d = hcnt_q + 4'd1;
        end else begin
          state_d   = ST_IDLE;
          m2_fall_d = 1'b1;
          if (hcnt_q < 4'(MIN_HIGH))
            glitch_d = 1'b1;
          else if (!rw_q && sel_hit(addr_q, SEL_MASK, SEL_MATCH))
            push_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge map_rst) begin
    if (map_rst) begin
      state_q   <= ST_IDLE;
      m2_d_q    <= 1'b0;
      hcnt_q    <= 4'd0;
      rw_q      <= 1'b0;
      addr_q    <= '0;
      dat_q     <= '0;
      push_q    <= 1'b0;
      m2_fall_q <= 1'b0;
      glitch_q  <= 1'b0;
      fill_q    <= 3'd0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      m2_d_q    <= m2_d_d;
      hcnt_q    <= hcnt_d;
      rw_q      <= rw_d;
      addr_q    <= addr_d;
      dat_q     <= dat_d;
      push_q    <= push_d;
      m2_fall_q <= m2_fall_d;
      glitch_q  <= glitch_d;
      fill_q    <= fill_d;
      armed_q   <= armed_d;
    end
  end

  wr_entry_t push_data;
  assign push_data = '{addr: addr_q, dat: dat_q};

  wr_fifo2 u_fifo (
    .clk       (clk),
    .rst       (map_rst),
    .push      (push_q),
    .push_data (push_data),
    .wr        (wr),
    .ovf       (ovf)
  );

  assign m2_fall = m2_fall_q;
  assign glitch  = glitch_q;

endmodule

// File: tb/tb_m2_wr_capture.sv
// tb_m2_wr_capture: directed bench for m2_wr_capture (default parameters).
// Inputs change 1 ns after the rising edge; outputs are observed on the
// falling edge by a monitor that counts pulses and logs every pop.
module tb_m2_wr_capture;

  logic        clk = 1'b0;
  logic        map_rst = 1'b1;
  logic        m2 = 1'b0;
  logic        cpu_rw = 1'b1;
  logic [15:0] cpu_addr = 16'h0000;
  logic [7:0]  cpu_dat = 8'h00;
  logic        m2_fall, glitch, ovf;

  m2_wr_capture_if wr_if ();

  m2_wr_capture dut (
    .clk      (clk),
    .map_rst  (map_rst),
    .m2       (m2),
    .cpu_rw   (cpu_rw),
    .cpu_addr (cpu_addr),
    .cpu_dat  (cpu_dat),
    .wr       (wr_if.master),
    .m2_fall  (m2_fall),
    .glitch   (glitch),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor
  int          fall_cnt = 0;
  int          glitch_cnt = 0;
  int          valid_cyc = 0;
  int          valid_rise = -1;
  logic        valid_prev = 1'b0;
  logic [23:0] popped [$];

  always @(negedge clk) begin
    if (!map_rst) begin
      if (m2_fall) fall_cnt++;
      if (glitch)  glitch_cnt++;
      if (wr_if.wr_valid) begin
        valid_cyc++;
        if (!valid_prev) valid_rise = cyc;
        if (wr_if.wr_ready) begin
          popped.push_back({wr_if.wr_addr, wr_if.wr_dat});
          $display("[%0d] pop addr=%h dat=%h", cyc, wr_if.wr_addr, wr_if.wr_dat);
        end
      end
      valid_prev = wr_if.wr_valid;
    end else begin
      valid_prev = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int k_edge;

  // One CPU cycle: M2 high for 'hi' clk edges, then low. With pop_on_fall,
  // wr_ready is raised right after m2_fall so the pop meets the push.
  task automatic m2_cycle(input logic [15:0] a, input logic [7:0] d, input logic rw,
                          input int hi, input bit pop_on_fall);
    tick(1);
    cpu_addr = a; cpu_dat = d; cpu_rw = rw; m2 = 1'b1;
    tick(hi);
    m2 = 1'b0;
    k_edge = cyc + 1;
    $display("[%0d] cpu %s addr=%h dat=%h high=%0d", cyc, rw ? "rd" : "wr", a, d, hi);
    if (pop_on_fall) begin
      for (int i = 0; i < 10 && !m2_fall; i++) tick(1);
      chk("fall_seen_for_pop", m2_fall, 1'b1);
      wr_if.wr_ready = 1'b1;
    end
    tick(6);
  endtask

  int fb, gb, vb, pb;

  task automatic mark();
    fb = fall_cnt; gb = glitch_cnt; vb = valid_cyc; pb = popped.size();
  endtask

  initial begin
    wr_if.wr_ready = 1'b1;
    tick(3);
    // Reset state
    chk("rst_valid", wr_if.wr_valid, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_fall", m2_fall, 1'b0);
    chk("rst_glitch", glitch, 1'b0);
    chk("rst_addr", wr_if.wr_addr, 16'h0000);
    chk("rst_dat", wr_if.wr_dat, 8'h00);
    map_rst = 1'b0;
    tick(6);

    // Single write
    mark();
    m2_cycle(16'h8155, 8'hA5, 1'b0, 6, 1'b0);
    tick(4);
    chk("w1_falls", fall_cnt - fb, 1);
    chk("w1_glitch", glitch_cnt - gb, 0);
    chk("w1_valid_cycles", valid_cyc - vb, 1);
    chk("w1_latency", valid_rise - k_edge, 3);
    chk("w1_pops", popped.size() - pb, 1);
    if (popped.size() > pb) chk("w1_entry", popped[pb], 24'h8155A5);

    // Glitch
    mark();
    m2_cycle(16'h8000, 8'h11, 1'b0, 2, 1'b0);
    tick(4);
    chk("gl_glitch", glitch_cnt - gb, 1);
    chk("gl_falls", fall_cnt - fb, 1);
    chk("gl_valid", valid_cyc - vb, 0);

    // Filtering: read, then write outside window
    mark();
    m2_cycle(16'h8000, 8'h22, 1'b1, 6, 1'b0);
    m2_cycle(16'h6000, 8'h33, 1'b0, 6, 1'b0);
    tick(4);
    chk("flt_falls", fall_cnt - fb, 2);
    chk("flt_valid", valid_cyc - vb, 0);
    chk("flt_glitch", glitch_cnt - gb, 0);

    // Backpressure / overflow
    mark();
    wr_if.wr_ready = 1'b0;
    m2_cycle(16'h8001, 8'h01, 1'b0, 6, 1'b0);
    chk("bp_head1", wr_if.wr_addr, 16'h8001);
    m2_cycle(16'h8002, 8'h02, 1'b0, 6, 1'b0);
    chk("bp_ovf_full", ovf, 1'b0);
    chk("bp_head2", wr_if.wr_addr, 16'h8001);
    m2_cycle(16'h8003, 8'h03, 1'b0, 6, 1'b0);
    chk("bp_ovf", ovf, 1'b1);
    chk("bp_head3", wr_if.wr_addr, 16'h8001);
    chk("bp_headdat", wr_if.wr_dat, 8'h01);
    chk("bp_valid", wr_if.wr_valid, 1'b1);
    wr_if.wr_ready = 1'b1;
    tick(5);
    chk("bp_pops", popped.size() - pb, 2);
    if (popped.size() >= pb + 2) begin
      chk("bp_pop0", popped[pb], 24'h800101);
      chk("bp_pop1", popped[pb+1], 24'h800202);
    end
    chk("bp_empty", wr_if.wr_valid, 1'b0);
    chk("bp_ovf_sticky", ovf, 1'b1);

    // Reset mid-operation
    wr_if.wr_ready = 1'b0;
    m2_cycle(16'h8010, 8'h10, 1'b0, 6, 1'b0);
    chk("mr_one_entry", wr_if.wr_valid, 1'b1);
    cpu_addr = 16'h8011; cpu_dat = 8'h12; cpu_rw = 1'b0; m2 = 1'b1;
    tick(3);
    map_rst = 1'b1;
    #1;
    chk("mr_valid_clr", wr_if.wr_valid, 1'b0);
    chk("mr_ovf_clr", ovf, 1'b0);
    tick(2);
    map_rst = 1'b0;
    mark();
    tick(5);
    m2 = 1'b0;
    tick(8);
    chk("mr_no_fall", fall_cnt - fb, 0);
    chk("mr_no_valid", valid_cyc - vb, 0);
    wr_if.wr_ready = 1'b1;
    m2_cycle(16'h8020, 8'h5A, 1'b0, 6, 1'b0);
    tick(3);
    chk("mr_fresh_pops", popped.size() - pb, 1);
    if (popped.size() > pb) chk("mr_fresh_entry", popped[pb], 24'h80205A);

    // Full with concurrent pop
    mark();
    wr_if.wr_ready = 1'b0;
    m2_cycle(16'h8001, 8'h11, 1'b0, 6, 1'b0);
    m2_cycle(16'h8002, 8'h22, 1'b0, 6, 1'b0);
    chk("cp_valid", wr_if.wr_valid, 1'b1);
    m2_cycle(16'h8004, 8'h44, 1'b0, 6, 1'b1);
    tick(4);
    chk("cp_ovf", ovf, 1'b0);
    chk("cp_pops", popped.size() - pb, 3);
    if (popped.size() >= pb + 3) begin
      chk("cp_pop0", popped[pb], 24'h800111);
      chk("cp_pop1", popped[pb+1], 24'h800222);
      chk("cp_pop2", popped[pb+2], 24'h800444);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
